// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default reset PC, instruction size and buffer entry layout.
package instruction_fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_2000;
    localparam logic [63:0] INST_BYTES       = 64'd4;

    localparam int PC_W    = 64;
    localparam int INST_W  = 32;
    // Buffer entry: {instruction word, fetch address}.
    localparam int ENTRY_W = INST_W + PC_W;

    // Redirect targets are word aligned; the low two bits are dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer. Push is accepted when not full, or when
// full with a same-cycle pop. Flush empties the buffer and overrides any
// push or pop in the same cycle. The head output reads zero while empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    // Next pointer and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observable through the gated head.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign empty_o = empty;
    assign count_o = count_q;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one word read at a time to instruction
// memory, buffers returned words with their addresses in fetch_fifo and
// presents the buffer head to the decoder.
//
// Handshakes: a memory request is a single-cycle mem_req pulse with
// mem_addr; exactly one mem_rvalid answers it, at least one cycle later.
// The decoder side is valid/ready: a word transfers on a cycle where both
// inst_valid and inst_ready are high; inst_valid, instructionLine and
// inst_pc hold steady until that transfer or a flush.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic         mem_req,
    output logic [63:0]  mem_addr,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    input  logic         halt,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  instructionLine,
    output logic [63:0]  inst_pc,
    output logic         halted,
    output fetch_state_e dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  req_addr_q, req_addr_d;

    logic               req_c;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] fifo_wdata;

    // Returned word is stored alongside the address it was fetched from.
    assign fifo_wdata = {mem_rdata, req_addr_q};

    // Next state, PC and buffer control; halt overrides everything else.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req_c      = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    pc_d       = align_pc(redirect_pc);
                end else if (fifo_count < DEPTH_CNT) begin
                    req_c      = 1'b1;
                    req_addr_d = pc_q;
                    pc_d       = pc_q + INST_BYTES;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    // Old-path data is never buffered; if it has not arrived
                    // yet it must still be absorbed in DRAIN.
                    fifo_flush = 1'b1;
                    pc_d       = align_pc(redirect_pc);
                    state_d    = mem_rvalid ? FETCH : DRAIN;
                end else if (mem_rvalid) begin
                    fifo_push = 1'b1;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = align_pc(redirect_pc);
                end
                if (mem_rvalid) begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (halt) begin
            state_d    = HALT;
            pc_d       = pc_q;
            req_c      = 1'b0;
            fifo_push  = 1'b0;
            fifo_flush = 1'b1;
        end
    end

    // Sequencer state, PC and outstanding request address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // A request is never presented while reset is held.
    assign mem_req  = reset_n && req_c;
    assign mem_addr = mem_req ? pc_q : '0;

    assign fifo_pop = inst_valid && inst_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_fifo (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign inst_valid      = !fifo_empty;
    assign instructionLine = fifo_head[ENTRY_W-1:PC_W];
    assign inst_pc         = fifo_head[PC_W-1:0];
    assign halted          = (state_q == HALT);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small latency-configurable
// instruction memory model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n = 1'b0;
    logic         mem_req;
    logic [63:0]  mem_addr;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_pc = '0;
    logic         halt = 1'b0;
    logic         inst_valid;
    logic         inst_ready = 1'b0;
    logic [31:0]  instructionLine;
    logic [63:0]  inst_pc;
    logic         halted;
    fetch_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    instruction_fetch dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .instructionLine (instructionLine),
        .inst_pc         (inst_pc),
        .halted          (halted),
        .dbg_state       (dbg_state)
    );

    // ---------------- memory model ----------------
    int          mem_lat = 1;
    logic        inj_valid = 1'b0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [63:0] mem_pend_addr = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hC880_0006 + (a[31:0] - 32'h0000_2000);
    endfunction

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_word(mem_pend_addr);
                mem_busy   <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
        if (inj_valid) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= 32'hDEAD_BEEF;
        end
        if (mem_req) begin
            if (mem_lat <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_word(mem_addr);
            end else begin
                mem_busy      <= 1'b1;
                mem_cnt       <= mem_lat - 1;
                mem_pend_addr <= mem_addr;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Holds reset for several cycles, then releases it on a falling edge.
    task automatic apply_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b0;
        inj_valid      = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        mem_lat = 1;
        apply_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++; $display("FAIL rst_prefill inst_valid got %0b exp 1", inst_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL rst_mem_req got %0b exp 0", mem_req);
        end
        checks++;
        if (mem_addr !== 64'h0) begin
            errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL rst_inst_valid got %0b exp 0", inst_valid);
        end
        checks++;
        if (instructionLine !== 32'h0) begin
            errors++; $display("FAIL rst_line got %h exp 0", instructionLine);
        end
        checks++;
        if (inst_pc !== 64'h0) begin
            errors++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++; $display("FAIL rst_halted got %0b exp 0", halted);
        end
        checks++;
        if (dbg_state !== FETCH) begin
            errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, FETCH);
        end
    endtask

    task automatic test_basic_fetch();
        mem_lat = 1;
        apply_reset();
        inst_ready = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h2000) begin
            errors++; $display("FAIL basic_req0 got req=%0b addr=%h exp req=1 addr=2000", mem_req, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== WAIT || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL basic_wait got st=%0d req=%0b v=%0b exp st=1 req=0 v=0", dbg_state, mem_req, inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || instructionLine !== 32'hC880_0006 || inst_pc !== 64'h2000) begin
            errors++; $display("FAIL basic_first got v=%0b line=%h pc=%h exp v=1 line=c8800006 pc=2000", inst_valid, instructionLine, inst_pc);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h2004) begin
            errors++; $display("FAIL basic_req1 got req=%0b addr=%h exp req=1 addr=2004", mem_req, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL basic_gap got v=%0b exp 0", inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || instructionLine !== 32'hC880_000A || inst_pc !== 64'h2004) begin
            errors++; $display("FAIL basic_second got v=%0b line=%h pc=%h exp v=1 line=c880000a pc=2004", inst_valid, instructionLine, inst_pc);
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int req_cnt;
        logic [63:0] req_addrs[$];
        mem_lat = 1;
        req_cnt = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_req === 1'b1) begin
                req_cnt++;
                req_addrs.push_back(mem_addr);
            end
            if (i == 6) inj_valid = 1'b1;
            if (i == 7) inj_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (req_cnt != 2) begin
            errors++; $display("FAIL bp_req_count got %0d exp 2", req_cnt);
        end else begin
            checks++;
            if (req_addrs[0] !== 64'h2000 || req_addrs[1] !== 64'h2004) begin
                errors++; $display("FAIL bp_req_addrs got %h %h exp 2000 2004", req_addrs[0], req_addrs[1]);
            end
        end
        checks++;
        if (dbg_state !== FETCH || mem_req !== 1'b0) begin
            errors++; $display("FAIL bp_full_idle got st=%0d req=%0b exp st=0 req=0", dbg_state, mem_req);
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h2000 || instructionLine !== 32'hC880_0006) begin
            errors++; $display("FAIL bp_head0 got v=%0b pc=%h line=%h exp v=1 pc=2000 line=c8800006", inst_valid, inst_pc, instructionLine);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h2004 || instructionLine !== 32'hC880_000A) begin
            errors++; $display("FAIL bp_head1 got v=%0b pc=%h line=%h exp v=1 pc=2004 line=c880000a", inst_valid, inst_pc, instructionLine);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h2008) begin
            errors++; $display("FAIL bp_resume got req=%0b addr=%h exp req=1 addr=2008", mem_req, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained got v=%0b exp 0", inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h2008 || instructionLine !== 32'hC880_000E) begin
            errors++; $display("FAIL bp_head2 got v=%0b pc=%h line=%h exp v=1 pc=2008 line=c880000e", inst_valid, inst_pc, instructionLine);
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int got;
        mem_lat = 3;
        apply_reset();
        inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== WAIT) begin
            errors++; $display("FAIL rdw_wait got st=%0d exp 1", dbg_state);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3002;
        @(negedge clk);
        checks++;
        if (dbg_state !== DRAIN || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rdw_drain got st=%0d req=%0b v=%0b exp st=2 req=0 v=0", dbg_state, mem_req, inst_valid);
        end
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(negedge clk);
        checks++;
        if (dbg_state !== DRAIN || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rdw_stale got st=%0d req=%0b v=%0b exp st=2 req=0 v=0", dbg_state, mem_req, inst_valid);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== FETCH || mem_req !== 1'b1 || mem_addr !== 64'h3000 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rdw_refetch got st=%0d req=%0b addr=%h v=%0b exp st=0 req=1 addr=3000 v=0", dbg_state, mem_req, mem_addr, inst_valid);
        end
        got = 0;
        for (int k = 0; k < 12 && got == 0; k++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) got = 1;
        end
        checks++;
        if (got == 0) begin
            errors++; $display("FAIL rdw_timeout got no inst_valid exp inst_valid");
        end else begin
            checks++;
            if (inst_pc !== 64'h3000 || instructionLine !== 32'hC880_1006) begin
                errors++; $display("FAIL rdw_first got pc=%h line=%h exp pc=3000 line=c8801006", inst_pc, instructionLine);
            end
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_same();
        int got;
        mem_lat = 1;
        apply_reset();
        inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== WAIT) begin
            errors++; $display("FAIL rds_wait got st=%0d exp 1", dbg_state);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        @(negedge clk);
        checks++;
        if (dbg_state !== FETCH || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rds_discard got st=%0d v=%0b exp st=0 v=0", dbg_state, inst_valid);
        end
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h4000) begin
            errors++; $display("FAIL rds_req got req=%0b addr=%h exp req=1 addr=4000", mem_req, mem_addr);
        end
        got = 0;
        for (int k = 0; k < 8 && got == 0; k++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) got = 1;
        end
        checks++;
        if (got == 0) begin
            errors++; $display("FAIL rds_timeout got no inst_valid exp inst_valid");
        end else begin
            checks++;
            if (inst_pc !== 64'h4000 || instructionLine !== 32'hC880_2006) begin
                errors++; $display("FAIL rds_first got pc=%h line=%h exp pc=4000 line=c8802006", inst_pc, instructionLine);
            end
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_fetch();
        int got;
        mem_lat = 1;
        apply_reset();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5003;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL rdf_noreq got req=%0b exp 0", mem_req);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== FETCH || mem_req !== 1'b0) begin
            errors++; $display("FAIL rdf_stay got st=%0d req=%0b exp st=0 req=0", dbg_state, mem_req);
        end
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h5000) begin
            errors++; $display("FAIL rdf_req got req=%0b addr=%h exp req=1 addr=5000", mem_req, mem_addr);
        end
        got = 0;
        for (int k = 0; k < 8 && got == 0; k++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) got = 1;
        end
        checks++;
        if (got == 0) begin
            errors++; $display("FAIL rdf_timeout got no inst_valid exp inst_valid");
        end else begin
            checks++;
            if (inst_pc !== 64'h5000 || instructionLine !== 32'hC880_3006) begin
                errors++; $display("FAIL rdf_first got pc=%h line=%h exp pc=5000 line=c8803006", inst_pc, instructionLine);
            end
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_halt();
        int bad;
        mem_lat = 1;
        apply_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++; $display("FAIL halt_prefill got v=%0b exp 1", inst_valid);
        end
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h6000;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL halt_same_cycle_req got req=%0b exp 0", mem_req);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || dbg_state !== HALT || inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL halt_enter got h=%0b st=%0d v=%0b req=%0b exp h=1 st=3 v=0 req=0", halted, dbg_state, inst_valid, mem_req);
        end
        halt           = 1'b0;
        redirect_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            redirect_valid = (i == 3);
            inst_ready     = (i >= 4);
            #1;
            if (mem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b1) bad++;
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL halt_hold got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_reset_mid_wait();
        int got;
        int waited;
        mem_lat = 3;
        apply_reset();
        @(negedge clk);
        checks++;
        if (dbg_state !== WAIT) begin
            errors++; $display("FAIL rmw_wait got st=%0d exp 1", dbg_state);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dbg_state !== FETCH || mem_req !== 1'b0 || mem_addr !== 64'h0 || inst_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL rmw_async got st=%0d req=%0b addr=%h v=%0b h=%0b exp st=0 req=0 addr=0 v=0 h=0", dbg_state, mem_req, mem_addr, inst_valid, halted);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h2000 || dbg_state !== FETCH) begin
            errors++; $display("FAIL rmw_restart got req=%0b addr=%h st=%0d exp req=1 addr=2000 st=0", mem_req, mem_addr, dbg_state);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== WAIT || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rmw_ignored got st=%0d v=%0b exp st=1 v=0", dbg_state, inst_valid);
        end
        got = 0;
        waited = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            @(negedge clk);
            waited++;
            if (inst_valid === 1'b1) got = 1;
        end
        checks++;
        if (got == 0) begin
            errors++; $display("FAIL rmw_timeout got no inst_valid exp inst_valid");
        end else begin
            checks++;
            if (waited != 3 || inst_pc !== 64'h2000 || instructionLine !== 32'hC880_0006) begin
                errors++; $display("FAIL rmw_first got wait=%0d pc=%h line=%h exp wait=3 pc=2000 line=c8800006", waited, inst_pc, instructionLine);
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same();
        test_redirect_fetch();
        test_halt();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h2000, meaning PC loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 2, meaning instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  read request to instruction memory, one-cycle pulse.
REQ-006 mem_addr  output  64  byte address of requested word, valid with mem_req.
REQ-007 mem_rvalid  input  1  read data valid; latency >=1 cycle after mem_req.
REQ-008 mem_rdata  input  32  little-endian instruction word, valid with mem_rvalid.
REQ-009 redirect_valid  input  1  branch/jump redirect from execute, single cycle.
REQ-010 redirect_pc  input  64  redirect target.
REQ-011 halt  input  1  stop fetching (halt instruction retired).
REQ-012 inst_valid  output  1  instructionLine/inst_pc valid to the decoder.
REQ-013 inst_ready  input  1  decoder accepts; transfer when inst_valid && inst_ready.
REQ-014 instructionLine  output  32  instruction word driven to instructionDecoder.
REQ-015 inst_pc  output  64  address of instructionLine.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 FSM states FETCH, WAIT, DRAIN, HALT; reset state FETCH.
REQ-018 FETCH: assert mem_req with mem_addr=pc only when fifo_count < FIFO_DEPTH; then pc<=pc+4 (64-bit wrap), go WAIT.
REQ-019 WAIT: on mem_rvalid push {mem_rdata, request address} into FIFO, go FETCH; at most one request outstanding.
REQ-020 mem_rvalid outside WAIT/DRAIN is ignored.
REQ-021 redirect_valid in FETCH: flush FIFO, pc<=redirect_pc with bits[1:0] forced to 0, no mem_req that cycle, stay FETCH.
REQ-022 redirect_valid in WAIT without same-cycle mem_rvalid: flush FIFO, load pc, go DRAIN; with same-cycle mem_rvalid: discard the data, flush, load pc, go FETCH.
REQ-023 DRAIN: wait for the stale mem_rvalid, discard it, go FETCH; a further redirect in DRAIN reloads pc only.
REQ-024 halt (any state): flush FIFO, go HALT; halt has priority over redirect in the same cycle; outstanding response discarded.
REQ-025 HALT: no mem_req, inst_valid=0, halted=1; exit only via reset.
REQ-026 inst_valid = FIFO non-empty; instructionLine/inst_pc = FIFO head; combinational from registered FIFO state.
REQ-027 Simultaneous push and pop allowed, including when full; count unchanged.
REQ-028 Flush overrides same-cycle push and pop; inst_valid low the cycle after flush.
REQ-029 Throughput: with 1-cycle memory and inst_ready=1, one instruction per 2 cycles; first inst_valid 2 cycles after reset release.

Reset
REQ-030 reset_n low asynchronously: pc=RESET_PC, state=FETCH, FIFO empty, mem_req=0, mem_addr=0, inst_valid=0, instructionLine=0, inst_pc=0, halted=0.
REQ-031 reset_n asserted mid-WAIT abandons the request; a later mem_rvalid is ignored until a new request issues.

Structure
REQ-032 Shared package holds fetch state enum, RESET_PC default, and INST_BYTES=4 constant.
REQ-033 Instruction buffer is sub-module fetch_fifo (synchronous FIFO, flush input, width 96).

Verification
REQ-034 Reset release, 1-cycle memory returning 32'hC8800006 at 0x2000, inst_ready=1 -> mem_addr 0x2000 then 0x2004; instructionLine=32'hC8800006, inst_pc=0x2000 two cycles after release.
REQ-035 inst_ready=0 for 10 cycles -> exactly 2 words buffered, no mem_req while full, words emitted in order 0x2000, 0x2004 when ready rises.
REQ-036 Redirect to 0x3002 during WAIT with 3-cycle memory -> stale response dropped, next mem_addr=0x3000, no instruction from old path reaches output.
REQ-037 Redirect in same cycle as mem_rvalid -> data discarded, next mem_addr=redirect target, FSM FETCH.
REQ-038 halt and redirect same cycle -> halted=1, no further mem_req, inst_valid=0 until reset.
REQ-039 reset_n pulsed low mid-WAIT, late mem_rvalid arrives -> ignored, outputs at reset values, fetch restarts at 0x2000.
